// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//
// Shares the single-ported data_memory between the core load/store port and
// the DMA/debug port. At most one request is granted per cycle. The grant is
// combinational and arrives in the same cycle as the request. The winner's
// response (rvalid/rdata/err) is registered and appears in the following
// cycle. Back-to-back grants are fully pipelined.
//
// Arbitration:
//   default build        : the core has fixed priority. A saturating
//                          starvation counter lets DMA win once it has been
//                          denied STARVE_LIMIT cycles in a row.
//   DMEM_ARB_RR_EN build : two-way round-robin on a 1-bit last-winner
//                          register. STARVE_LIMIT is ignored.
//
// Memory map: word = addr[9:2] (256 x 64-bit), addr[1:0] ignored.
// A request is in range iff addr[63:10] == 0. An out-of-range request is
// granted and answered with err = 1, but never touches memory.
//
// Parameters:
//   STARVE_LIMIT   denied DMA cycles before DMA is forced through (1..255)
//
// Ports:
//   clock, reset_n                         clock, async active-low reset
//   core_req/we/addr/wdata                 core request
//   core_gnt                               core request accepted (comb)
//   core_rvalid/rdata/err                  core response (registered)
//   dma_*                                  same set for the DMA port
//   mem_write/mem_read/mem_address/
//   mem_write_data                         drive to data_memory
//   mem_read_data                          combinational data_memory output
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        core_req,
  input  logic        core_we,
  input  logic [63:0] core_addr,
  input  logic [63:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [63:0] core_rdata,
  output logic        core_err,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [63:0] dma_addr,
  input  logic [63:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [63:0] dma_rdata,
  output logic        dma_err,

  output logic        mem_write,
  output logic        mem_read,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  // ---------------------------------------------------------------------------
  // Winner selection (before reset gating)
  // ---------------------------------------------------------------------------
  logic core_sel;
  logic dma_sel;

`ifdef DMEM_ARB_RR_EN
  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DMA  = 1'b1
  } port_e;

  port_e last_gnt;

  // On a conflict the port that did not win last time goes first.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    core_sel = core_req;
    dma_sel  = dma_req;
    if (core_req && dma_req) begin
      dma_sel  = (last_gnt == PORT_CORE);
      core_sel = (last_gnt == PORT_DMA);
    end
  end

  // Resets to DMA so the core wins the first conflict after reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt <= PORT_DMA;
    end else if (core_gnt) begin
      last_gnt <= PORT_CORE;
    end else if (dma_gnt) begin
      last_gnt <= PORT_DMA;
    end
  end
`else
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;

  // Core has priority unless DMA has waited STARVE_LIMIT cycles in a row.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    dma_sel  = dma_req && (!core_req || (starve_cnt == STARVE_MAX));
    core_sel = core_req && !dma_sel;
  end

  // Counts consecutive denied DMA cycles and saturates at the limit. It clears
  // whenever DMA is granted or stops requesting.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (dma_req && !dma_gnt) begin
      if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  // Grants are forced low while reset is held. A transaction whose grant
  // cycle is hit by reset therefore never writes memory and never responds.
  assign core_gnt = reset_n && core_sel;
  assign dma_gnt  = reset_n && dma_sel;

  // ---------------------------------------------------------------------------
  // Winner request mux and memory drive
  // ---------------------------------------------------------------------------
  logic        win_we;
  logic [63:0] win_addr;
  logic [63:0] win_wdata;
  logic        win_in_range;
  logic        any_gnt;
  logic [63:0] resp_data;

  always_comb begin
    win_we       = dma_sel ? dma_we    : core_we;
    win_addr     = dma_sel ? dma_addr  : core_addr;
    win_wdata    = dma_sel ? dma_wdata : core_wdata;
    win_in_range = (win_addr[63:10] == '0);
    any_gnt      = core_gnt || dma_gnt;
  end

  always_comb begin
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (any_gnt) begin
      mem_address = win_addr;
      // Out-of-range requests are granted but must not touch memory.
      if (win_in_range) begin
        mem_write      = win_we;
        mem_read       = !win_we;
        mem_write_data = win_we ? win_wdata : '0;
      end
    end
  end

  // Data returned with the response: the memory word for an in-range read,
  // zero for writes and out-of-range requests.
  always_comb begin
    resp_data = '0;
    if (win_in_range && !win_we) begin
      resp_data = mem_read_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers. rvalid pulses for one cycle after each grant. rdata
  // and err hold until the next response on the same port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      core_err    <= 1'b0;
    end else begin
      core_rvalid <= core_gnt;
      if (core_gnt) begin
        core_rdata <= resp_data;
        core_err   <= !win_in_range;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_err    <= 1'b0;
    end else begin
      dma_rvalid <= dma_gnt;
      if (dma_gnt) begin
        dma_rdata <= resp_data;
        dma_err   <= !win_in_range;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
//
// Directed bench for data_memory_arbiter with a behavioural data_memory model.
// Inputs change on the falling edge. Combinational outputs are sampled 1 ns
// later. Registered responses are sampled 1 ns after the rising edge. When
// DMEM_ARB_RR_EN is defined, the conflict expectations switch to round-robin.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

  logic        clock;
  logic        reset_n;

  logic        core_req, core_we;
  logic [63:0] core_addr, core_wdata;
  logic        core_gnt, core_rvalid, core_err;
  logic [63:0] core_rdata;

  logic        dma_req, dma_we;
  logic [63:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [63:0] dma_rdata;

  logic        mem_write, mem_read;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] PATTERN = 64'hDEAD_BEEF_CAFE_BABE;

  data_memory_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .core_req       (core_req),
    .core_we        (core_we),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_gnt       (core_gnt),
    .core_rvalid    (core_rvalid),
    .core_rdata     (core_rdata),
    .core_err       (core_err),
    .dma_req        (dma_req),
    .dma_we         (dma_we),
    .dma_addr       (dma_addr),
    .dma_wdata      (dma_wdata),
    .dma_gnt        (dma_gnt),
    .dma_rvalid     (dma_rvalid),
    .dma_rdata      (dma_rdata),
    .dma_err        (dma_err),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Behavioural data_memory: combinational read, write on the rising edge.
  logic [63:0] mem_model [256];
  always @(posedge clock) begin
    if (mem_write) mem_model[mem_address[9:2]] <= mem_write_data;
  end
  assign mem_read_data = mem_read ? mem_model[mem_address[9:2]] : 64'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Applies both ports' requests at the falling edge. Returns 1 ns later so
  // the combinational outputs can be sampled.
  task automatic drive(input logic cr, input logic cw, input logic [63:0] ca,
                       input logic [63:0] cd, input logic dr, input logic dw,
                       input logic [63:0] da, input logic [63:0] dd);
    @(negedge clock);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dma_req  = dr; dma_we  = dw; dma_addr  = da; dma_wdata  = dd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  // Moves to just after the next rising edge, where the responses are stable.
  task automatic to_response();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    #12;
    checks++; if ({core_rvalid, core_err, dma_rvalid, dma_err} !== 4'b0) begin
      failures++; $display("FAIL rst_flags: got %b want 0000", {core_rvalid, core_err, dma_rvalid, dma_err}); end
    checks++; if ({core_rdata, dma_rdata} !== 128'd0) begin
      failures++; $display("FAIL rst_rdata: core %h dma %h want 0", core_rdata, dma_rdata); end
    // Requests presented while reset is held must not be granted.
    core_req = 1'b1; core_we = 1'b1; dma_req = 1'b1;
    #1;
    checks++; if ({core_gnt, dma_gnt, mem_write, mem_read} !== 4'b0) begin
      failures++; $display("FAIL rst_gnt: got %b want 0000", {core_gnt, dma_gnt, mem_write, mem_read}); end
    core_req = 1'b0; core_we = 1'b0; dma_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Both ports read every cycle. Default build: core x4, DMA x1, repeating.
  // Round-robin build: alternating, core first.
  task automatic test_conflict();
    for (int i = 0; i < 10; i++) begin
      logic exp_core;
`ifdef DMEM_ARB_RR_EN
      exp_core = (i % 2 == 0);
`else
      exp_core = (i % 5 != 4);
`endif
      drive(1'b1, 1'b0, 64'h0, 64'd0, 1'b1, 1'b0, 64'h8, 64'd0);
      checks++; if ({core_gnt, dma_gnt} !== {exp_core, !exp_core}) begin
        failures++; $display("FAIL conflict_gnt[%0d]: got %b want %b", i, {core_gnt, dma_gnt}, {exp_core, !exp_core}); end
      checks++; if (mem_address !== (exp_core ? 64'h0 : 64'h8) || mem_read !== 1'b1) begin
        failures++; $display("FAIL conflict_mem[%0d]: addr %h rd %b", i, mem_address, mem_read); end
      to_response();
      checks++; if ({core_rvalid, dma_rvalid} !== {exp_core, !exp_core}) begin
        failures++; $display("FAIL conflict_rvalid[%0d]: got %b want %b", i, {core_rvalid, dma_rvalid}, {exp_core, !exp_core}); end
    end
    idle();
    to_response();
  endtask

  task automatic test_core_write_read();
    drive(1'b1, 1'b1, 64'h0, PATTERN, 1'b0, 1'b0, 64'd0, 64'd0);
    checks++; if ({core_gnt, dma_gnt, mem_write, mem_read} !== 4'b1010) begin
      failures++; $display("FAIL wr_ctrl: got %b want 1010", {core_gnt, dma_gnt, mem_write, mem_read}); end
    checks++; if (mem_address !== 64'h0 || mem_write_data !== PATTERN) begin
      failures++; $display("FAIL wr_bus: addr %h data %h want 0 %h", mem_address, mem_write_data, PATTERN); end
    to_response();
    checks++; if ({core_rvalid, core_err} !== 2'b10 || core_rdata !== 64'd0) begin
      failures++; $display("FAIL wr_resp: rvalid/err %b rdata %h want 10 0", {core_rvalid, core_err}, core_rdata); end
    drive(1'b1, 1'b0, 64'h0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    checks++; if ({core_gnt, mem_write, mem_read} !== 3'b101 || mem_write_data !== 64'd0) begin
      failures++; $display("FAIL rd_ctrl: got %b wdata %h want 101 0", {core_gnt, mem_write, mem_read}, mem_write_data); end
    to_response();
    checks++; if ({core_rvalid, core_err} !== 2'b10 || core_rdata !== PATTERN) begin
      failures++; $display("FAIL rd_resp: rvalid/err %b rdata %h want 10 %h", {core_rvalid, core_err}, core_rdata, PATTERN); end
    idle();
    checks++; if ({core_gnt, dma_gnt, mem_write, mem_read} !== 4'b0 || mem_address !== 64'd0 || mem_write_data !== 64'd0) begin
      failures++; $display("FAIL idle_mem: ctrl %b addr %h data %h want 0", {core_gnt, dma_gnt, mem_write, mem_read}, mem_address, mem_write_data); end
    to_response();
    checks++; if (core_rvalid !== 1'b0 || core_rdata !== PATTERN) begin
      failures++; $display("FAIL rdata_hold: rvalid %b rdata %h want 0 %h", core_rvalid, core_rdata, PATTERN); end
  endtask

  task automatic test_out_of_range();
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h400, 64'hAAAA);
    checks++; if ({dma_gnt, mem_write, mem_read} !== 3'b100) begin
      failures++; $display("FAIL oor_ctrl: got %b want 100", {dma_gnt, mem_write, mem_read}); end
    to_response();
    checks++; if ({dma_rvalid, dma_err} !== 2'b11 || dma_rdata !== 64'd0) begin
      failures++; $display("FAIL oor_resp: rvalid/err %b rdata %h want 11 0", {dma_rvalid, dma_err}, dma_rdata); end
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 64'h0, 64'd0);
    to_response();
    checks++; if ({dma_rvalid, dma_err} !== 2'b10 || dma_rdata !== PATTERN) begin
      failures++; $display("FAIL oor_unchanged: rvalid/err %b rdata %h want 10 %h", {dma_rvalid, dma_err}, dma_rdata, PATTERN); end
    idle();
    to_response();
  endtask

  task automatic test_same_word();
    drive(1'b1, 1'b1, 64'h3FC, 64'h3333, 1'b1, 1'b0, 64'h3FC, 64'd0);
    checks++; if ({core_gnt, dma_gnt, mem_write} !== 3'b101 || mem_address !== 64'h3FC) begin
      failures++; $display("FAIL same_first: gnt/wr %b addr %h want 101 3fc", {core_gnt, dma_gnt, mem_write}, mem_address); end
    to_response();
    checks++; if ({core_rvalid, dma_rvalid} !== 2'b10) begin
      failures++; $display("FAIL same_resp1: got %b want 10", {core_rvalid, dma_rvalid}); end
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 64'h3FC, 64'd0);
    checks++; if ({core_gnt, dma_gnt} !== 2'b01) begin
      failures++; $display("FAIL same_second: got %b want 01", {core_gnt, dma_gnt}); end
    to_response();
    checks++; if ({dma_rvalid, dma_err} !== 2'b10 || dma_rdata !== 64'h3333) begin
      failures++; $display("FAIL same_data: rvalid/err %b rdata %h want 10 3333", {dma_rvalid, dma_err}, dma_rdata); end
    idle();
    to_response();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 64'h40, 64'h1111, 1'b0, 1'b0, 64'd0, 64'd0);
    to_response();
    drive(1'b1, 1'b0, 64'h40, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    to_response();
    checks++; if (core_rdata !== 64'h1111) begin
      failures++; $display("FAIL mid_prior: rdata %h want 1111", core_rdata); end
    // Write grant cycle: the read response is still visible here.
    drive(1'b1, 1'b1, 64'h40, 64'h5555, 1'b0, 1'b0, 64'd0, 64'd0);
    checks++; if ({core_gnt, mem_write, core_rvalid} !== 3'b111) begin
      failures++; $display("FAIL mid_pre: gnt/wr/rvalid %b want 111", {core_gnt, mem_write, core_rvalid}); end
    reset_n = 1'b0;
    #1;
    checks++; if ({core_gnt, dma_gnt, mem_write, mem_read, core_rvalid, core_err} !== 6'b0) begin
      failures++; $display("FAIL mid_flags: got %b want 000000", {core_gnt, dma_gnt, mem_write, mem_read, core_rvalid, core_err}); end
    checks++; if ({mem_address, mem_write_data, core_rdata} !== 192'd0) begin
      failures++; $display("FAIL mid_buses: addr %h wdata %h rdata %h want 0", mem_address, mem_write_data, core_rdata); end
    core_req = 1'b0;
    #2;
    reset_n = 1'b1;
    to_response();
    checks++; if (core_rvalid !== 1'b0) begin
      failures++; $display("FAIL mid_no_resp: rvalid %b want 0", core_rvalid); end
    drive(1'b1, 1'b0, 64'h40, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    to_response();
    checks++; if ({core_rvalid, core_rdata} !== {1'b1, 64'h1111}) begin
      failures++; $display("FAIL mid_kept: rvalid %b rdata %h want 1 1111", core_rvalid, core_rdata); end
    idle();
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_core_write_read();
    test_out_of_range();
    test_same_word();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-ported `data_memory` between two requesters: the core load/store port and a DMA/debug port. Each cycle it grants at most one request, drives the memory's control, address and data ports, and returns registered read data to the winner one cycle later. Core requests have fixed priority over DMA requests, and a starvation counter guarantees DMA forward progress. The block sits between the core's MEM stage and `data_memory`.

## Interface
- `STARVE_LIMIT`, 4: number of consecutive denied DMA cycles after which DMA wins the next arbitration. Legal range 1..255.
- `clock` in 1: system clock. All state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `core_req` in 1: core request valid.
- `core_we` in 1: 1 = write, 0 = read.
- `core_addr` in 64: byte address.
- `core_wdata` in 64: write data.
- `core_gnt` out 1: request accepted this cycle (combinational).
- `core_rvalid` out 1: `core_rdata` valid (one-cycle pulse).
- `core_rdata` out 64: read response data.
- `core_err` out 1: accompanies `core_rvalid`; the address was out of range.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_rdata`, `dma_err`: same as the `core_*` set, for the DMA port.
- `mem_write` out 1: to `data_memory.mem_write`.
- `mem_read` out 1: to `data_memory.mem_read`.
- `mem_address` out 64: to `data_memory.address`.
- `mem_write_data` out 64: to `data_memory.write_data`.
- `mem_read_data` in 64: from `data_memory.read_data`. Combinational; 0 when `mem_read` = 0.

## Operation
- **Memory map.** A word is selected by `addr[9:2]` (256 × 64-bit words). `addr[1:0]` is ignored.
- **Range check.** A request is in range iff `addr[63:10] == 0`.
- **Winner selection.**
  - DMA wins when `dma_req` && (!`core_req` || `starve_cnt` == `STARVE_LIMIT`).
  - Otherwise core wins when `core_req`.
  - Neither requesting: no grant; all `mem_*` outputs are 0.
- **Grant.** The winner's `*_gnt` is high in the same cycle as its request. A request with no grant must be held unchanged by the requester until granted.
- **Memory drive, winner in range.**
  - `mem_address` = winner's addr.
  - `mem_write` = we; `mem_read` = !we.
  - `mem_write_data` = wdata when we = 1, else 0.
- **Memory drive, winner out of range.** The request is granted, but `mem_write` = `mem_read` = 0 (no memory access).
- **Response.**
  - Every granted request, read or write, produces a one-cycle `*_rvalid` pulse on the winner's port in the following cycle.
  - `*_rdata` = `mem_read_data` captured at the grant edge for an in-range read; 0 for writes and out-of-range requests.
  - `*_err` = 1 only for an out-of-range request.
- **Starvation counter `starve_cnt`** (8 bits, saturates at `STARVE_LIMIT`):
  - increments when `dma_req` && !`dma_gnt`;
  - clears when `dma_gnt` or !`dma_req`.
- **Response hold.** `*_rdata` and `*_err` hold their last value until the next response on that port. Only `*_rvalid` pulses.
- **Pipelining.** Back-to-back grants are allowed, including to the same port; response N+1 follows response N with no gap.

## Timing
- **Reset.** While `reset_n` = 0:
  - `core_gnt`, `dma_gnt` and all `mem_*` outputs are forced to 0;
  - `*_rvalid`, `*_rdata`, `*_err` and `starve_cnt` are cleared asynchronously.
- **Reset during a transaction.** Reset asserted in a grant cycle drops that transaction: no write reaches memory and no response is issued after release.
- **Write latency.** Memory is updated at the rising edge ending the grant cycle.
- **Read latency.** `*_rvalid` rises 1 cycle after grant.
- **Write then read, same address.**
  - Write granted in cycle N, read granted in cycle N+1: the read returns the new data.
  - Simultaneous core write and DMA read of the same word: core wins. The DMA read is granted in a later cycle and sees the new value.

## Configuration
- `DMEM_ARB_RR_EN`:
  - **Defined:** fixed priority and the starvation counter are replaced by round-robin. A 1-bit `last_gnt` register records the last winner. When both ports request, the port that did not win last is granted; `last_gnt` resets to DMA, so core wins the first conflict. `STARVE_LIMIT` is ignored.
  - **Undefined:** fixed core priority with the starvation counter, as described above.

## Test plan
- **Core write, then core read.** Core writes 0xDEADBEEFCAFEBABE to 0x0; core reads 0x0 the next cycle → `core_rvalid` the cycle after the read grant with that value; `core_err` = 0.
- **Conflict, default build.**
  - Both ports issue reads every cycle with `STARVE_LIMIT` = 4: grants go core ×4, DMA ×1, repeating.
  - `dma_rvalid` pulses every 5th cycle.
- **Conflict, `DMEM_ARB_RR_EN` build.** Same stimulus as above → grants alternate core/DMA, starting with core.
- **Out-of-range write.** DMA writes 0xAAAA to 0x400 → `dma_gnt` = 1, `mem_write` = 0; next cycle `dma_rvalid` = 1, `dma_err` = 1. A following read of 0x0 is unchanged.
- **Same-cycle conflict on one word.**
  - Core writes 0x3333 to 0x3FC while DMA reads 0x3FC in the same cycle.
  - Core is granted first; the DMA read is granted next cycle and returns 0x3333.
- **Reset mid-operation.**
  - Assert `reset_n` = 0 for 3 ns inside a core write grant cycle to 0x40 (write data 0x5555).
  - All outputs are 0 immediately.
  - No `rvalid` follows, and a read of 0x40 after release returns the prior contents.
